mem_bus_responder: RTL and testbench

- Synthesizable memory-side responder for the core's tagged memory bus (proc2mem_* / mem2proc_*).
- It is the other end of the bus from the processor's memory interface.
- Accepts load/store commands, allocates a 4-bit transaction tag, and returns data with that tag after a fixed latency.
- Backed by internal 64-bit-line storage.
- Replaces the behavioural memory model in FPGA and synthesis builds; the core bench attaches it unchanged.

---
 rtl/mem_bus_responder_pkg.sv | 39 +++
 rtl/mem_bus_responder_tag_alloc.sv | 57 +++++
 rtl/mem_bus_responder.sv | 111 +++++++++++
 tb/tb_mem_bus_responder.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_responder_pkg.sv
// Shared bus definitions for the tagged memory bus and its responder.
package mem_bus_responder_pkg;

    localparam int XLEN            = 32;
    localparam int MEM_64BIT_LINES = 8192;
    localparam int MEM_TAG_W       = 4;

    typedef enum logic [1:0] {
        BUS_NONE  = 2'h0,
        BUS_LOAD  = 2'h1,
        BUS_STORE = 2'h2
    } BUS_COMMAND;

    typedef enum logic [1:0] {
        BYTE   = 2'h0,
        HALF   = 2'h1,
        WORD   = 2'h2,
        DOUBLE = 2'h3
    } MEM_SIZE;

    typedef struct packed {
        logic                 valid;
        logic [MEM_TAG_W-1:0] tag;
        logic [63:0]          data;
    } pipe_entry_t;

    // Byte lanes of a 64-bit line touched by an access of the given size at the given offset.
    function automatic logic [7:0] lane_mask(input logic [2:0] offset, input logic [1:0] size);
        logic [7:0] base;
        case (size)
            BYTE:    base = 8'h01;
            HALF:    base = 8'h03;
            WORD:    base = 8'h0F;
            default: base = 8'hFF;
        endcase
        return base << offset;
    endfunction

endpackage

// File: rtl/mem_bus_responder_tag_alloc.sv
// Round-robin transaction tag allocator: busy mask, allocation pointer, alloc/free ports.
module mem_tag_allocator
    import mem_bus_responder_pkg::*;
#(
    parameter int NUM_TAGS = 15
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 alloc_i,
    input  logic [MEM_TAG_W-1:0] free_tag_i,
    output logic [MEM_TAG_W-1:0] next_tag_o,
    output logic                 has_free_o
);

    logic [NUM_TAGS:1]    busy_q, busy_d;
    logic [MEM_TAG_W-1:0] ptr_q, ptr_d;

    // First free tag at or after the pointer; scanned backwards so the nearest one wins.
    always_comb begin
        int                   cand_int;
        logic [MEM_TAG_W-1:0] cand;
        next_tag_o = '0;
        has_free_o = 1'b0;
        for (int i = NUM_TAGS - 1; i >= 0; i--) begin
            cand_int = int'(ptr_q) + i;
            if (cand_int > NUM_TAGS) cand_int = cand_int - NUM_TAGS;
            cand = MEM_TAG_W'(cand_int);
            if (!busy_q[cand]) begin
                next_tag_o = cand;
                has_free_o = 1'b1;
            end
        end
    end

    // The search above uses busy_q, so a tag freed this cycle only becomes allocatable next cycle.
    always_comb begin
        busy_d = busy_q;
        ptr_d  = ptr_q;
        if (free_tag_i != '0) busy_d[free_tag_i] = 1'b0;
        if (alloc_i) begin
            busy_d[next_tag_o] = 1'b1;
            ptr_d = (next_tag_o == MEM_TAG_W'(NUM_TAGS)) ? MEM_TAG_W'(1) : next_tag_o + MEM_TAG_W'(1);
        end
    end

    // Busy mask and pointer registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            busy_q <= '0;
            ptr_q  <= MEM_TAG_W'(1);
        end else begin
            busy_q <= busy_d;
            ptr_q  <= ptr_d;
        end
    end

endmodule

// File: rtl/mem_bus_responder.sv
// Memory-side responder for the tagged memory bus: accepts loads/stores, returns tagged data after LATENCY.
module mem_bus_responder
    import mem_bus_responder_pkg::*;
#(
    parameter int MEM_LINES = MEM_64BIT_LINES,
    parameter int LATENCY   = 10,
    parameter int NUM_TAGS  = 15
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [1:0]           proc2mem_command,
    input  logic [XLEN-1:0]      proc2mem_addr,
    input  logic [63:0]          proc2mem_data,
    input  logic [1:0]           proc2mem_size,
    input  logic                 bus_stall,
    output logic [MEM_TAG_W-1:0] mem2proc_response,
    output logic [63:0]          mem2proc_data,
    output logic [MEM_TAG_W-1:0] mem2proc_tag,
    output logic                 mem_error
);

    localparam int LINE_W = $clog2(MEM_LINES);

    logic [63:0]          mem_q [MEM_LINES];
    pipe_entry_t          pipe_q [LATENCY];
    pipe_entry_t          entry_d, tail;
    logic [MEM_TAG_W-1:0] tag_q, free_tag, next_tag;
    logic [63:0]          data_q, line_rd, line_merged, data_shifted;
    logic                 err_q, err_d;
    logic                 is_load, is_store, req_valid, misaligned, out_of_range, illegal;
    logic                 has_free, accept;
    logic [LINE_W-1:0]    line_idx;
    logic [7:0]           mask;

    assign is_load      = (proc2mem_command == BUS_LOAD);
    assign is_store     = (proc2mem_command == BUS_STORE);
    assign req_valid    = is_load | is_store;
    assign out_of_range = (proc2mem_addr >= XLEN'(MEM_LINES * 8));
    assign illegal      = out_of_range | misaligned;
    assign accept       = req_valid & ~bus_stall & has_free & ~illegal;
    assign err_d        = req_valid & ~bus_stall & illegal;
    assign line_idx     = proc2mem_addr[LINE_W+2:3];
    assign line_rd      = mem_q[line_idx];
    assign mask         = lane_mask(proc2mem_addr[2:0], proc2mem_size);
    assign data_shifted = proc2mem_data << {proc2mem_addr[2:0], 3'b000};
    assign tail         = pipe_q[LATENCY-1];
    assign free_tag     = tail.valid ? tail.tag : '0;

    assign mem2proc_response = accept ? next_tag : '0;
    assign mem2proc_tag      = tag_q;
    assign mem2proc_data     = data_q;
    assign mem_error         = err_q;

    mem_tag_allocator #(.NUM_TAGS(NUM_TAGS)) u_tag_alloc (
        .clock      (clock),
        .reset_n    (reset_n),
        .alloc_i    (accept),
        .free_tag_i (free_tag),
        .next_tag_o (next_tag),
        .has_free_o (has_free)
    );

    // Alignment check against the access size.
    always_comb begin
        misaligned = 1'b0;
        case (proc2mem_size)
            HALF:    misaligned = proc2mem_addr[0];
            WORD:    misaligned = |proc2mem_addr[1:0];
            DOUBLE:  misaligned = |proc2mem_addr[2:0];
            default: misaligned = 1'b0;
        endcase
    end

    // Store data merged into the current line through the active byte lanes.
    always_comb begin
        line_merged = line_rd;
        for (int b = 0; b < 8; b++) begin
            if (mask[b]) line_merged[b*8 +: 8] = data_shifted[b*8 +: 8];
        end
    end

    // Entry entering the latency pipe; stores return zero data.
    always_comb begin
        entry_d       = '0;
        entry_d.valid = accept;
        entry_d.tag   = accept ? next_tag : '0;
        entry_d.data  = (accept && is_load) ? line_rd : '0;
    end

    // Line storage; deliberately untouched by reset so contents survive it.
    always_ff @(posedge clock) begin
        if (accept && is_store) mem_q[line_idx] <= line_merged;
    end

    // Latency pipe and registered return/error outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < LATENCY; i++) pipe_q[i] <= '0;
            tag_q  <= '0;
            data_q <= '0;
            err_q  <= 1'b0;
        end else begin
            pipe_q[0] <= entry_d;
            for (int i = 1; i < LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
            tag_q  <= tail.valid ? tail.tag : '0;
            data_q <= tail.valid ? tail.data : '0;
            err_q  <= err_d;
        end
    end

endmodule

// File: tb/tb_mem_bus_responder.sv
// Bench for mem_bus_responder: two instances (LATENCY 10 and 14) against a transaction-level model.
module tb_mem_bus_responder;
    import mem_bus_responder_pkg::*;

    typedef struct {
        int          due;
        logic [3:0]  tag;
        logic [63:0] data;
    } ret_t;

    logic        clock   = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  cmd     = 2'd0;
    logic [31:0] addr    = 32'd0;
    logic [63:0] wdata   = 64'd0;
    logic [1:0]  size    = 2'd0;
    logic        stall   = 1'b0;

    logic [3:0]  resp  [2];
    logic [63:0] rdata [2];
    logic [3:0]  rtag  [2];
    logic        rerr  [2];

    bit          m_busy [2][16];
    int          m_ptr  [2];
    logic [63:0] m_mem  [2][8192];
    logic        exp_err[2];
    ret_t        exp_q  [2][$];
    int          edge_n;
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clock = ~clock;

    mem_bus_responder #(.LATENCY(10)) dut10 (
        .clock(clock), .reset_n(reset_n), .proc2mem_command(cmd), .proc2mem_addr(addr),
        .proc2mem_data(wdata), .proc2mem_size(size), .bus_stall(stall),
        .mem2proc_response(resp[0]), .mem2proc_data(rdata[0]), .mem2proc_tag(rtag[0]), .mem_error(rerr[0])
    );

    mem_bus_responder #(.LATENCY(14)) dut14 (
        .clock(clock), .reset_n(reset_n), .proc2mem_command(cmd), .proc2mem_addr(addr),
        .proc2mem_data(wdata), .proc2mem_size(size), .bus_stall(stall),
        .mem2proc_response(resp[1]), .mem2proc_data(rdata[1]), .mem2proc_tag(rtag[1]), .mem_error(rerr[1])
    );

    function automatic int lat(input int k);
        return (k == 0) ? 10 : 14;
    endfunction

    task automatic check_val(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    function automatic bit model_legal();
        return (addr < 32'd65536) && ((addr % (32'd1 << size)) == 32'd0);
    endfunction

    // Tag the responder should grant this cycle: first non-busy tag scanning round-robin from the pointer.
    function automatic logic [3:0] model_resp(input int k);
        int t;
        if (cmd == BUS_NONE || stall || !model_legal()) return 4'd0;
        for (int i = 0; i < 15; i++) begin
            t = ((m_ptr[k] - 1 + i) % 15) + 1;
            if (!m_busy[k][t]) return 4'(t);
        end
        return 4'd0;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int t = 0; t < 16; t++) m_busy[k][t] = 1'b0;
            m_ptr[k]   = 1;
            exp_err[k] = 1'b0;
            exp_q[k].delete();
        end
    endtask

    // One bus cycle: drive, check response mid-cycle, update model at the edge, check registered outputs.
    task automatic cyc(input logic [1:0] c, input logic [31:0] a, input logic [63:0] d,
                       input logic [1:0] s, input logic st);
        logic [3:0]  r;
        logic [63:0] line;
        ret_t        e;
        int          idx;
        cmd = c; addr = a; wdata = d; size = s; stall = st;
        @(negedge clock);
        for (int k = 0; k < 2; k++) begin
            r = model_resp(k);
            check_val($sformatf("resp L%0d e%0d", lat(k), edge_n + 1), 64'(resp[k]), 64'(r));
            exp_err[k] = (c != BUS_NONE) && !st && !model_legal();
            if (r != 4'd0) begin
                idx = int'(a >> 3);
                m_busy[k][r] = 1'b1;
                m_ptr[k]     = (int'(r) % 15) + 1;
                e.due  = edge_n + 1 + lat(k);
                e.tag  = r;
                e.data = (c == BUS_LOAD) ? m_mem[k][idx] : 64'd0;
                if (c == BUS_STORE) begin
                    line = m_mem[k][idx];
                    for (int b = 0; b < (1 << s); b++)
                        line[(int'(a % 8) + b) * 8 +: 8] = d[b * 8 +: 8];
                    m_mem[k][idx] = line;
                end
                exp_q[k].push_back(e);
            end
        end
        @(posedge clock);
        edge_n++;
        #1;
        for (int k = 0; k < 2; k++) begin
            if (exp_q[k].size() > 0 && exp_q[k][0].due == edge_n) begin
                e = exp_q[k].pop_front();
                m_busy[k][e.tag] = 1'b0;
                check_val($sformatf("tag L%0d e%0d", lat(k), edge_n), 64'(rtag[k]), 64'(e.tag));
                check_val($sformatf("data L%0d e%0d", lat(k), edge_n), rdata[k], e.data);
            end else begin
                check_val($sformatf("idle tag L%0d e%0d", lat(k), edge_n), 64'(rtag[k]), 64'd0);
            end
            check_val($sformatf("err L%0d e%0d", lat(k), edge_n), 64'(rerr[k]), 64'(exp_err[k]));
            exp_err[k] = 1'b0;
        end
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) cyc(BUS_NONE, 32'd0, 64'd0, 2'd0, 1'b0);
    endtask

    // Reset asserted between edges; outputs must clear without waiting for a clock.
    task automatic async_reset();
        cmd = BUS_NONE; stall = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            check_val($sformatf("rst tag L%0d", lat(k)), 64'(rtag[k]), 64'd0);
            check_val($sformatf("rst data L%0d", lat(k)), rdata[k], 64'd0);
            check_val($sformatf("rst err L%0d", lat(k)), 64'(rerr[k]), 64'd0);
        end
        model_reset();
        drain(2);
        reset_n = 1'b1;
    endtask

    task automatic random_cycle();
        logic [1:0]  c, s;
        logic [31:0] a;
        logic        st;
        int          line, off, sel;
        c    = 2'($urandom_range(0, 2));
        s    = 2'($urandom_range(0, 3));
        line = int'($urandom_range(0, 15));
        off  = (int'($urandom_range(0, 7)) >> s) << s;
        sel  = int'($urandom_range(0, 15));
        st   = ($urandom_range(0, 7) == 0);
        if (sel == 0 && s != 2'd0) off = off | 1;
        a = 32'(line * 8 + off);
        if (sel == 1) a = 32'd65536 + a;
        if (sel < 2) st = 1'b0;
        cyc(c, a, {$urandom, $urandom}, s, st);
    endtask

    initial begin
        model_reset();
        edge_n = 0;
        @(posedge clock);
        #1;
        for (int k = 0; k < 2; k++) begin
            check_val($sformatf("init tag L%0d", lat(k)), 64'(rtag[k]), 64'd0);
            check_val($sformatf("init data L%0d", lat(k)), rdata[k], 64'd0);
            check_val($sformatf("init err L%0d", lat(k)), 64'(rerr[k]), 64'd0);
        end
        reset_n = 1'b1;

        // Preload lines 0..15; line 4 holds the known pattern.
        for (int i = 0; i < 16; i++)
            cyc(BUS_STORE, 32'(i * 8), (i == 4) ? 64'h0123_4567_89AB_CDEF : {$urandom, $urandom}, DOUBLE, 1'b0);
        drain(16);

        // Storage survives reset; first load afterwards gets tag 1.
        async_reset();
        cyc(BUS_LOAD, 32'd32, 64'd0, DOUBLE, 1'b0);
        drain(16);

        // Store then load on the next cycle sees the merged line.
        cyc(BUS_STORE, 32'd36, 64'h0000_0000_DEAD_BEEF, WORD, 1'b0);
        cyc(BUS_LOAD, 32'd32, 64'd0, DOUBLE, 1'b0);
        drain(16);

        for (int i = 0; i < 12; i++) cyc(BUS_LOAD, 32'((i % 16) * 8), 64'd0, DOUBLE, 1'b0);
        drain(16);

        // Refusals: stall, misaligned half, out of range.
        cyc(BUS_LOAD, 32'd32, 64'd0, DOUBLE, 1'b1);
        cyc(BUS_LOAD, 32'd33, 64'd0, HALF, 1'b0);
        cyc(BUS_LOAD, 32'd65536, 64'd0, DOUBLE, 1'b0);
        drain(2);

        // Full tag wrap from a fresh pointer.
        async_reset();
        for (int i = 0; i < 17; i++) cyc(BUS_LOAD, 32'((i % 16) * 8), 64'd0, DOUBLE, 1'b0);
        drain(16);

        // Reset with five loads in flight: nothing stale may come back.
        for (int i = 0; i < 5; i++) cyc(BUS_LOAD, 32'(i * 8), 64'd0, DOUBLE, 1'b0);
        async_reset();
        drain(16);
        cyc(BUS_LOAD, 32'd32, 64'd0, DOUBLE, 1'b0);
        drain(16);

        for (int i = 0; i < 400; i++) random_cycle();
        drain(16);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
